// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the 10-bit count type used by the timing
// generator and the pixel-drawing controllers.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] count_t;

  localparam int unsigned CLK_DIV_DEF = 4;
  localparam int unsigned H_TOTAL_DEF = 800;
  localparam int unsigned V_TOTAL_DEF = 525;
  localparam int unsigned H_SYNC_DEF  = 96;
  localparam int unsigned V_SYNC_DEF  = 2;
  localparam int unsigned H_START_DEF = 144;
  localparam int unsigned H_END_DEF   = 783;
  localparam int unsigned V_START_DEF = 35;
  localparam int unsigned V_END_DEF   = 514;

  function automatic logic in_window(input count_t c, input count_t lo, input count_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-MOD counter with enable; wrap is high on the enabled cycle that
// returns the count to zero, so counters can be cascaded directly.
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MOD = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output count_t count,
  output logic   wrap
);

  localparam count_t LAST = count_t'(MOD - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + count_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: clock divider, horizontal/vertical counters, sync and
// visible-window decode, and a once-per-frame tick for game logic.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned H_TOTAL = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL = V_TOTAL_DEF,
  parameter int unsigned H_SYNC  = H_SYNC_DEF,
  parameter int unsigned V_SYNC  = V_SYNC_DEF,
  parameter int unsigned H_START = H_START_DEF,
  parameter int unsigned H_END   = H_END_DEF,
  parameter int unsigned V_START = V_START_DEF,
  parameter int unsigned V_END   = V_END_DEF
) (
  input  logic   clk,
  input  logic   rst,
  output logic   pix_en,
  output count_t hCount,
  output count_t vCount,
  output logic   hSync,
  output logic   vSync,
  output logic   bright,
  output logic   frame_tick
);

  count_t unused_div_count;
  logic   div_wrap;
  logic   h_wrap;
  logic   v_wrap;

  mod_counter #(.MOD(CLK_DIV)) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (unused_div_count),
    .wrap  (div_wrap)
  );

  mod_counter #(.MOD(H_TOTAL)) u_hcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pix_en),
    .count (hCount),
    .wrap  (h_wrap)
  );

  mod_counter #(.MOD(V_TOTAL)) u_vcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .count (vCount),
    .wrap  (v_wrap)
  );

  // frame_tick registers the edge that moves the counters to (0,0), so it
  // is high exactly while they first read (0,0); reset never produces it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_en     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      pix_en     <= div_wrap;
      frame_tick <= v_wrap;
    end
  end

  assign hSync  = (hCount >= count_t'(H_SYNC));
  assign vSync  = (vCount >= count_t'(V_SYNC));
  assign bright = in_window(hCount, count_t'(H_START), count_t'(H_END)) &&
                  in_window(vCount, count_t'(V_START), count_t'(V_END));

endmodule
